// File: rtl/multicycle_ctrl_fsm.sv
// Hardwired control FSM for the multicycle RV32I core: sequences IF/ID/EX/MEM/WB
// over the shared datapath and counts retired instructions.
module multicycle_ctrl_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic             mem_ready,
  input  logic             is_halted,
  output logic             pc_write,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             is_ecall,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    pc_write  = 1'b0;
    pc_source = 1'b0;
    i_or_d    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = '0;
    alu_src_a = 1'b0;
    alu_src_b = '0;
    alu_op    = '0;
    is_ecall  = 1'b0;
    halted    = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_ID;
        end
      end

      S_ID: begin
        alu_src_b = 2'd1;
        case (opcode)
          OP_ECALL: begin
            is_ecall = 1'b1;
            state_d  = is_halted ? S_HALT : S_WB;
          end
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR: state_d = S_EX;
          default: state_d = S_WB;
        endcase
      end

      S_EX: begin
        state_d = S_WB;
        case (opcode)
          OP_R: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd1;
          end
          OP_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd1;
            alu_op    = 2'd1;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd1;
            state_d   = S_MEM;
          end
          OP_BR: begin
            alu_src_a = 1'b1;
            alu_op    = 2'd2;
            if (bcond) begin
              pc_write  = 1'b1;
              pc_source = 1'b1;
              retire    = 1'b1;
              state_d   = S_IF;
            end
          end
          OP_JAL: begin
            alu_src_b = 2'd2;
            reg_write = 1'b1;
            wb_sel    = 2'd2;
            pc_write  = 1'b1;
            pc_source = 1'b1;
            retire    = 1'b1;
            state_d   = S_IF;
          end
          OP_JALR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd1;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            alu_src_b = 2'd2;
            pc_write  = 1'b1;
            retire    = 1'b1;
            state_d   = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        alu_src_b = 2'd2;
        pc_write  = 1'b1;
        pc_source = (opcode == OP_JALR);
        retire    = 1'b1;
        state_d   = S_IF;
        case (opcode)
          OP_R, OP_I: reg_write = 1'b1;
          OP_LOAD: begin
            reg_write = 1'b1;
            wb_sel    = 2'd1;
          end
          OP_JALR: begin
            reg_write = 1'b1;
            wb_sel    = 2'd2;
          end
          default: ;
        endcase
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_IF;
    endcase

    // Reset is asynchronous, so outputs must drop while it is low, not at the next edge.
    if (!reset) begin
      pc_write  = 1'b0;
      pc_source = 1'b0;
      i_or_d    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      wb_sel    = '0;
      alu_src_a = 1'b0;
      alu_src_b = '0;
      alu_op    = '0;
      is_ecall  = 1'b0;
      halted    = 1'b0;
    end

    retired_d = retire ? retired_q + CNT_ONE : retired_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule
